// File: rtl/rf_access_arbiter_if.sv
// rtl/rf_access_arbiter_if.sv - requester and register-file signal bundle for rf_access_arbiter
// slave is the arbiter's view; master is the requesters/RF side.
interface rf_access_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic              i_req_m0;
  logic              i_we_m0;
  logic [ADDR_W-1:0] i_addr_m0;
  logic [DATA_W-1:0] i_wdata_m0;
  logic              o_gnt_m0;
  logic              o_rvalid_m0;
  logic [DATA_W-1:0] o_rdata_m0;
  logic              o_err_m0;

  logic              i_req_m1;
  logic              i_we_m1;
  logic [ADDR_W-1:0] i_addr_m1;
  logic [DATA_W-1:0] i_wdata_m1;
  logic              o_gnt_m1;
  logic              o_rvalid_m1;
  logic [DATA_W-1:0] o_rdata_m1;
  logic              o_err_m1;

  logic              o_rf_wr_en;
  logic              o_rf_rd_en;
  logic [ADDR_W-1:0] o_rf_address;
  logic [DATA_W-1:0] o_rf_wr_data;
  logic [DATA_W-1:0] i_rf_rd_data;
  logic              i_rf_rd_valid;

  modport slave (
    input  i_req_m0, i_we_m0, i_addr_m0, i_wdata_m0,
    output o_gnt_m0, o_rvalid_m0, o_rdata_m0, o_err_m0,
    input  i_req_m1, i_we_m1, i_addr_m1, i_wdata_m1,
    output o_gnt_m1, o_rvalid_m1, o_rdata_m1, o_err_m1,
    output o_rf_wr_en, o_rf_rd_en, o_rf_address, o_rf_wr_data,
    input  i_rf_rd_data, i_rf_rd_valid
  );

  modport master (
    output i_req_m0, i_we_m0, i_addr_m0, i_wdata_m0,
    input  o_gnt_m0, o_rvalid_m0, o_rdata_m0, o_err_m0,
    output i_req_m1, i_we_m1, i_addr_m1, i_wdata_m1,
    input  o_gnt_m1, o_rvalid_m1, o_rdata_m1, o_err_m1,
    input  o_rf_wr_en, o_rf_rd_en, o_rf_address, o_rf_wr_data,
    output i_rf_rd_data, i_rf_rd_valid
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// rtl/rf_access_arbiter.sv - round-robin arbiter sharing a single-port register file between m0 and m1
// One transaction in flight; reads abort with an error after RD_TIMEOUT wait cycles.
module rf_access_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 7
) (
  input logic                i_clk,
  input logic                i_rst,
  rf_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT} state_t;

  localparam logic [3:0] L_TIMEOUT = 4'(RD_TIMEOUT);

  state_t     r_state;
  logic       r_rr_ptr;
  logic       r_owner;
  logic [3:0] r_cnt;

  logic              w_any_req;
  logic              w_pick_m1;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [3:0]        w_cnt_next;

  // r_rr_ptr = 1 gives m1 the tie; a lone requester always wins.
  assign w_any_req   = bus.i_req_m0 | bus.i_req_m1;
  assign w_pick_m1   = bus.i_req_m1 & (~bus.i_req_m0 | r_rr_ptr);
  assign w_sel_we    = w_pick_m1 ? bus.i_we_m1    : bus.i_we_m0;
  assign w_sel_addr  = w_pick_m1 ? bus.i_addr_m1  : bus.i_addr_m0;
  assign w_sel_wdata = w_pick_m1 ? bus.i_wdata_m1 : bus.i_wdata_m0;
  assign w_cnt_next  = r_cnt + 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_rr_ptr         <= 1'b0;
      r_owner          <= 1'b0;
      r_cnt            <= 4'd0;
      bus.o_gnt_m0     <= 1'b0;
      bus.o_gnt_m1     <= 1'b0;
      bus.o_rvalid_m0  <= 1'b0;
      bus.o_rvalid_m1  <= 1'b0;
      bus.o_err_m0     <= 1'b0;
      bus.o_err_m1     <= 1'b0;
      bus.o_rdata_m0   <= '0;
      bus.o_rdata_m1   <= '0;
      bus.o_rf_wr_en   <= 1'b0;
      bus.o_rf_rd_en   <= 1'b0;
      bus.o_rf_address <= '0;
      bus.o_rf_wr_data <= '0;
    end else begin
      // Grant, strobes and result flags are single-cycle pulses.
      bus.o_gnt_m0    <= 1'b0;
      bus.o_gnt_m1    <= 1'b0;
      bus.o_rvalid_m0 <= 1'b0;
      bus.o_rvalid_m1 <= 1'b0;
      bus.o_err_m0    <= 1'b0;
      bus.o_err_m1    <= 1'b0;
      bus.o_rf_wr_en  <= 1'b0;
      bus.o_rf_rd_en  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner          <= w_pick_m1;
            r_rr_ptr         <= ~w_pick_m1;
            bus.o_gnt_m0     <= ~w_pick_m1;
            bus.o_gnt_m1     <= w_pick_m1;
            bus.o_rf_address <= w_sel_addr;
            bus.o_rf_wr_data <= w_sel_wdata;
            if (w_sel_we) begin
              bus.o_rf_wr_en <= 1'b1;
              r_state        <= S_WR;
            end else begin
              bus.o_rf_rd_en <= 1'b1;
              r_state        <= S_RD;
            end
          end
        end

        S_WR: r_state <= S_IDLE;

        S_RD: begin
          r_cnt   <= 4'd0;
          r_state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          // Valid is checked first so a late answer on the last cycle still wins.
          if (bus.i_rf_rd_valid) begin
            if (r_owner) begin
              bus.o_rdata_m1  <= bus.i_rf_rd_data;
              bus.o_rvalid_m1 <= 1'b1;
            end else begin
              bus.o_rdata_m0  <= bus.i_rf_rd_data;
              bus.o_rvalid_m0 <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (w_cnt_next == L_TIMEOUT) begin
            if (r_owner) begin
              bus.o_rdata_m1 <= '0;
              bus.o_err_m1   <= 1'b1;
            end else begin
              bus.o_rdata_m0 <= '0;
              bus.o_err_m0   <= 1'b1;
            end
            r_cnt   <= w_cnt_next;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb/tb_rf_access_arbiter.sv - directed and randomized bench for rf_access_arbiter
// Expected values come from a transaction-level model: round-robin owner, RF memory, read latency rule.
module tb_rf_access_arbiter;
  localparam int T = 7;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int         rr;
  logic [7:0] mem [16];
  logic [7:0] exp_rdata [2];

  rf_access_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  rf_access_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_TIMEOUT(T)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, bus.o_gnt_m0, bus.o_gnt_m1, bus.o_rvalid_m0, bus.o_rvalid_m1,
                        bus.o_err_m0, bus.o_err_m1, bus.o_rf_wr_en, bus.o_rf_rd_en}, 32'd0);
    chk({tag, "_bus"}, {4'd0, bus.o_rf_address, bus.o_rf_wr_data, bus.o_rdata_m0, bus.o_rdata_m1}, 32'd0);
  endtask

  // One complete access; dly = cycles after the rd_en cycle at which the RF answers.
  task automatic txn(input bit r0, input bit r1, input bit we0, input bit we1,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, input int dly);
    int w;
    bit we;
    logic [3:0] a;
    logic [7:0] wd;
    bit pv, pe;
    bus.i_req_m0 = r0; bus.i_we_m0 = we0; bus.i_addr_m0 = a0; bus.i_wdata_m0 = d0;
    bus.i_req_m1 = r1; bus.i_we_m1 = we1; bus.i_addr_m1 = a1; bus.i_wdata_m1 = d1;
    w  = (r0 && r1) ? rr : (r0 ? 0 : 1);
    rr = 1 - w;
    we = (w == 1) ? we1 : we0;
    a  = (w == 1) ? a1 : a0;
    wd = (w == 1) ? d1 : d0;
    tick();
    chk("gnt_m0", bus.o_gnt_m0, w == 0);
    chk("gnt_m1", bus.o_gnt_m1, w == 1);
    chk("wr_en", bus.o_rf_wr_en, we);
    chk("rd_en", bus.o_rf_rd_en, !we);
    chk("rf_addr", bus.o_rf_address, a);
    if (we) chk("rf_wdata", bus.o_rf_wr_data, wd);
    bus.i_req_m0 = 1'b0;
    bus.i_req_m1 = 1'b0;
    if (we) begin
      mem[a] = wd;
      tick();
      chk("wr_gnt_off", {bus.o_gnt_m0, bus.o_gnt_m1, bus.o_rf_wr_en, bus.o_rf_rd_en}, 4'd0);
      chk("wr_no_result", {bus.o_rvalid_m0, bus.o_rvalid_m1, bus.o_err_m0, bus.o_err_m1}, 4'd0);
    end else begin
      for (int c = 1; c <= T + 3; c++) begin
        tick();
        pv = (dly <= T) && (c == dly + 1);
        pe = (dly > T) && (c == T + 1);
        if (pv) exp_rdata[w] = mem[a];
        if (pe) exp_rdata[w] = 8'h00;
        chk("rvalid_m0", bus.o_rvalid_m0, pv && (w == 0));
        chk("rvalid_m1", bus.o_rvalid_m1, pv && (w == 1));
        chk("err_m0", bus.o_err_m0, pe && (w == 0));
        chk("err_m1", bus.o_err_m1, pe && (w == 1));
        chk("rdata_m0", bus.o_rdata_m0, exp_rdata[0]);
        chk("rdata_m1", bus.o_rdata_m1, exp_rdata[1]);
        chk("rd_strobes_off", {bus.o_rf_wr_en, bus.o_rf_rd_en, bus.o_gnt_m0, bus.o_gnt_m1}, 4'd0);
        bus.i_rf_rd_valid = (c == dly);
        bus.i_rf_rd_data  = (c == dly) ? mem[a] : 8'($urandom);
      end
      bus.i_rf_rd_valid = 1'b0;
    end
  endtask

  initial begin
    int p;
    rst = 1'b1;
    bus.i_req_m0 = 0; bus.i_we_m0 = 0; bus.i_addr_m0 = 0; bus.i_wdata_m0 = 0;
    bus.i_req_m1 = 0; bus.i_we_m1 = 0; bus.i_addr_m1 = 0; bus.i_wdata_m1 = 0;
    bus.i_rf_rd_valid = 0; bus.i_rf_rd_data = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    rr = 0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // m0 write, then m1 read answered one cycle after rd_en.
    txn(1, 0, 1, 0, 4'h3, 4'h0, 8'h5A, 8'h00, 1);
    mem[2] = 8'hC3;
    txn(0, 1, 0, 0, 4'h0, 4'h2, 8'h00, 8'h00, 1);

    // Both hold write requests: six alternating grants, two cycles apart.
    bus.i_req_m0 = 1; bus.i_we_m0 = 1; bus.i_addr_m0 = 4'h4; bus.i_wdata_m0 = 8'h11;
    bus.i_req_m1 = 1; bus.i_we_m1 = 1; bus.i_addr_m1 = 4'h9; bus.i_wdata_m1 = 8'h22;
    for (int c = 1; c <= 12; c++) begin
      int w;
      tick();
      w = -1;
      if (c % 2 == 1) begin
        w  = rr;
        rr = 1 - w;
      end
      chk("hold_gnt_m0", bus.o_gnt_m0, w == 0);
      chk("hold_gnt_m1", bus.o_gnt_m1, w == 1);
      if (c == 12) begin
        bus.i_req_m0 = 0;
        bus.i_req_m1 = 0;
      end
    end
    mem[4] = 8'h11;
    mem[9] = 8'h22;

    // m0 read with no answer times out; a retry returning 0x11 completes.
    txn(1, 0, 0, 0, 4'h7, 4'h0, 8'h00, 8'h00, 1000);
    mem[7] = 8'h11;
    txn(1, 0, 0, 0, 4'h7, 4'h0, 8'h00, 8'h00, 2);

    // Reset while waiting for read data, then a late rd_valid.
    bus.i_req_m1 = 1; bus.i_we_m1 = 0; bus.i_addr_m1 = 4'h5;
    tick();
    chk("rst_rd_gnt_m1", bus.o_gnt_m1, 1'b1);
    bus.i_req_m1 = 0;
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rst_in_wait");
    rst = 1'b0;
    bus.i_rf_rd_valid = 1; bus.i_rf_rd_data = 8'hAA;
    tick();
    chk("rst_late_valid", {bus.o_rvalid_m0, bus.o_rvalid_m1, bus.o_err_m0, bus.o_err_m1}, 4'd0);
    bus.i_rf_rd_valid = 0;
    rr = 0;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    txn(1, 1, 1, 1, 4'h1, 4'h6, 8'h3C, 8'h4D, 1);

    // m1 withdraws while m0's grant is pending.
    txn(0, 1, 1, 1, 4'h0, 4'h1, 8'h00, 8'h33, 1);
    bus.i_req_m0 = 1; bus.i_we_m0 = 1; bus.i_addr_m0 = 4'hA; bus.i_wdata_m0 = 8'h5C;
    bus.i_req_m1 = 1; bus.i_we_m1 = 1; bus.i_addr_m1 = 4'hB; bus.i_wdata_m1 = 8'h6D;
    tick();
    chk("wd_gnt_m0", bus.o_gnt_m0, 1'b1);
    chk("wd_gnt_m1", bus.o_gnt_m1, 1'b0);
    rr = 1;
    mem[10] = 8'h5C;
    bus.i_req_m0 = 0;
    bus.i_req_m1 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("wd_no_gnt", {bus.o_gnt_m0, bus.o_gnt_m1, bus.o_rf_rd_en}, 3'd0);
    end

    // Stray rd_valid while idle.
    bus.i_rf_rd_valid = 1; bus.i_rf_rd_data = 8'h77;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stray_rvalid", {bus.o_rvalid_m0, bus.o_rvalid_m1}, 2'd0);
      chk("stray_rdata", {bus.o_rdata_m0, bus.o_rdata_m1}, {exp_rdata[0], exp_rdata[1]});
    end
    bus.i_rf_rd_valid = 0;

    // Answer arrives on the last permitted wait cycle.
    txn(0, 1, 0, 0, 4'h0, 4'h9, 8'h00, 8'h00, T);

    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(1, 3);
      txn(p[0], p[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
          8'($urandom), 8'($urandom), $urandom_range(1, T + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
Shares the single-port register file between two requesters: m0, the command controller, and m1, the configuration/debug path. Each requester issues one read or write at a time. The block arbitrates round-robin, drives the RF strobes, address and write data, and waits for RF read data. It returns read data to the granted requester, or an error if the RF does not answer in time. It sits between the requesters and the RF; neither requester drives the RF directly.

Parameters:
ADDR_W, 4, RF address width
DATA_W, 8, RF data width
RD_TIMEOUT, 7, max cycles in S_RD_WAIT before abort; range 1..15

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_req_m0  input  1  m0 access request, held until o_gnt_m0 or withdrawn
i_we_m0  input  1  m0 direction: 1 = write, 0 = read
i_addr_m0  input  ADDR_W  m0 address
i_wdata_m0  input  DATA_W  m0 write data
o_gnt_m0  output  1  m0 grant pulse
o_rvalid_m0  output  1  m0 read-data-valid pulse
o_rdata_m0  output  DATA_W  m0 read data
o_err_m0  output  1  m0 read-timeout pulse
i_req_m1, i_we_m1, i_addr_m1, i_wdata_m1, o_gnt_m1, o_rvalid_m1, o_rdata_m1, o_err_m1: same as m0, for m1
o_rf_wr_en  output  1  RF write strobe
o_rf_rd_en  output  1  RF read strobe
o_rf_address  output  ADDR_W  RF address
o_rf_wr_data  output  DATA_W  RF write data
i_rf_rd_data  input  DATA_W  RF read data
i_rf_rd_valid  input  1  RF read-data-valid

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - all outputs 0; state = S_IDLE; rr_ptr = 0 (m0 has priority); timeout counter = 0.
  - Reset mid-transaction drops the transaction; no rvalid or err is produced for it.
- States: S_IDLE, S_WR, S_RD, S_RD_WAIT.
- S_IDLE arbitration:
  - Only m0 requesting: grant m0. Only m1 requesting: grant m1.
  - Both requesting: grant the requester selected by rr_ptr.
  - After any grant, rr_ptr points to the other requester.
  - Next state is S_WR when the granted we = 1, otherwise S_RD.
  - Address, write data, owner and direction are captured in the arbitration cycle.
- Grant timing: arbitration in cycle N gives o_gnt_mX = 1 in cycle N+1 for exactly one cycle. The RF strobe is also high in N+1.
- S_WR:
  - o_rf_wr_en = 1 with the captured address and data, for one cycle.
  - Next state is S_IDLE. Maximum write throughput is one write per 2 cycles.
- S_RD:
  - o_rf_rd_en = 1 with the captured address, for one cycle.
  - Next state is S_RD_WAIT; counter cleared.
- S_RD_WAIT:
  - i_rf_rd_valid = 1: o_rdata_owner <= i_rf_rd_data and o_rvalid_owner pulses for 1 cycle; go to S_IDLE.
  - Otherwise the counter increments. When the counter reaches RD_TIMEOUT: o_err_owner pulses for 1 cycle, o_rdata_owner <= 0, go to S_IDLE.
  - If rd_valid arrives in the same cycle the counter hits RD_TIMEOUT, valid wins; no err.
- i_rf_rd_valid outside S_RD_WAIT is ignored.
- o_rdata_mX holds its last value until the next rvalid or err for that requester.
- Request rules:
  - A requester keeps req, we, addr and wdata stable until its grant. Dropping req before grant withdraws the request with no side effect.
  - A req still high in the cycle after its grant counts as a new request.
  - Requests are sampled only in S_IDLE, so at most one transaction is outstanding.
- Strobes: o_rf_wr_en and o_rf_rd_en are never high together. The non-owner's outputs never pulse.

Test Plan:
- Reset, then m0 writes addr 0x3 data 0x5A: o_gnt_m0 and o_rf_wr_en high together for 1 cycle, 1 cycle after req; o_rf_address = 0x3, o_rf_wr_data = 0x5A; m1 outputs stay 0.
- m1 reads addr 0x2, RF returns 0xC3 one cycle after rd_en: o_rvalid_m1 pulses with o_rdata_m1 = 0xC3; o_rvalid_m0 stays 0.
- m0 and m1 hold write requests continuously for 6 grants: grant order m0, m1, m0, m1, m0, m1; each grant is 2 cycles apart.
- m0 reads addr 0x7, RF never returns valid: o_err_m0 pulses RD_TIMEOUT (7) cycles after entering S_RD_WAIT, o_rdata_m0 = 0x00. A later read of addr 0x7 returning 0x11 completes normally.
- i_rst asserted in S_RD_WAIT, then rd_valid arrives: all outputs 0, no rvalid; the next simultaneous request is granted to m0.
- Edge cases, three separate checks:
  - m1 drops req in the cycle a grant is pending to m0 → no m1 grant.
  - Stray i_rf_rd_valid in S_IDLE → no rvalid.
  - rd_valid in the cycle the counter hits timeout → rvalid, no err.
